// File: rtl/fir_pkg.sv
// Shared constants and the scale/saturate helper for the FIR receive path.
// The optional rounding stage is selected with the FIR_RX_ROUND_EN macro.
package fir_pkg;

  localparam int FIR_OUT_W  = 34;
  localparam int SAMPLE_W   = 16;
  localparam int DROP_CNT_W = 16;

  // Clamp a shifted (FIR_OUT_W+1)-bit value into a SAMPLE_W two's complement sample.
  function automatic logic [SAMPLE_W-1:0] sat_sample(input logic signed [FIR_OUT_W:0] v);
    logic signed [FIR_OUT_W:0] max_v;
    logic signed [FIR_OUT_W:0] min_v;
    max_v = (FIR_OUT_W+1)'((64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1);
    min_v = -max_v - (FIR_OUT_W+1)'(1);
    if (v > max_v)
      sat_sample = {1'b0, {(SAMPLE_W-1){1'b1}}};
    else if (v < min_v)
      sat_sample = {1'b1, {(SAMPLE_W-1){1'b0}}};
    else
      sat_sample = v[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/fir_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry an extra wrap bit
// so full and empty are told apart without a separate counter.
module fir_rx_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_en;
  logic         rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A pop frees the slot in the same cycle, so a write into a full FIFO is legal then.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fir_rx_sink.sv
// FIR output sink: scale/saturate to OUT_W, buffer in a FWFT FIFO, count overflow drops.
// Define FIR_RX_ROUND_EN for round-half-up before the shift; otherwise truncate.
module fir_rx_sink
  import fir_pkg::*;
#(
  parameter int IN_W  = FIR_OUT_W,
  parameter int OUT_W = SAMPLE_W,
  parameter int SHIFT = 15,
  parameter int DEPTH = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    s_axis_data_tvalid,
  input  logic [IN_W-1:0]         s_axis_data_tdata,
  output logic                    m_axis_data_tvalid,
  input  logic                    m_axis_data_tready,
  output logic [OUT_W-1:0]        m_axis_data_tdata,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    ovf,
  output logic [DROP_CNT_W-1:0]   drop_cnt,
  input  logic                    clr_ovf
);

  // Handshake: the input side has no ready and every valid beat is taken; the output
  // side transfers when m_axis_data_tvalid && m_axis_data_tready, and tvalid/tdata hold
  // steady until that transfer happens.

  localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [IN_W:0] MIN_V = -MAX_V - (IN_W+1)'(1);

  logic signed [IN_W:0] din_ext;
  logic signed [IN_W:0] scaled;
  logic [OUT_W-1:0]     sat_val;
  logic                 s1_valid;
  logic [OUT_W-1:0]     s1_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 drop;

  assign din_ext = {s_axis_data_tdata[IN_W-1], s_axis_data_tdata};

`ifdef FIR_RX_ROUND_EN
  localparam logic signed [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
  assign scaled = (din_ext + HALF) >>> SHIFT;
`else
  assign scaled = din_ext >>> SHIFT;
`endif

  always_comb begin
    sat_val = scaled[OUT_W-1:0];
    if (scaled > MAX_V)
      sat_val = {1'b0, {(OUT_W-1){1'b1}}};
    else if (scaled < MIN_V)
      sat_val = {1'b1, {(OUT_W-1){1'b0}}};
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= s_axis_data_tvalid;
      if (s_axis_data_tvalid) s1_data <= sat_val;
    end
  end

  assign m_axis_data_tvalid = !fifo_empty;
  assign pop  = m_axis_data_tvalid && m_axis_data_tready;
  assign drop = s1_valid && fifo_full && !pop;

  fir_rx_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (aclk),
    .rst   (areset),
    .push  (s1_valid),
    .pop   (pop),
    .wdata (s1_data),
    .rdata (m_axis_data_tdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // A drop in the same cycle as clr_ovf restarts the count at one instead of zero.
  always_ff @(posedge aclk) begin
    if (areset) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (clr_ovf)
        drop_cnt <= DROP_CNT_W'(1);
      else if (drop_cnt != {DROP_CNT_W{1'b1}})
        drop_cnt <= drop_cnt + 1'b1;
    end else if (clr_ovf) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_fir_rx_sink.sv
// Self-checking bench for fir_rx_sink: vector table, random stream and corner sequences.
// Expectations follow FIR_RX_ROUND_EN the same way the design does.
module tb_fir_rx_sink;

  localparam int DEPTH = 16;
  localparam int SHIFT = 15;

  logic        aclk = 1'b0;
  logic        areset;
  logic        s_tvalid;
  logic [33:0] s_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [15:0] m_tdata;
  logic [4:0]  level;
  logic        ovf;
  logic [15:0] drop_cnt;
  logic        clr_ovf;

  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  typedef struct {
    logic [33:0] din;
    logic [15:0] dout;
  } vec_t;
  vec_t vecs[10];

  fir_rx_sink #(.SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .aclk               (aclk),
    .areset             (areset),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tdata  (s_tdata),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_tready),
    .m_axis_data_tdata  (m_tdata),
    .level              (level),
    .ovf                (ovf),
    .drop_cnt           (drop_cnt),
    .clr_ovf            (clr_ovf)
  );

  // clock / watchdog
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: integer arithmetic on the signed input value.
  function automatic logic [15:0] model(input logic [33:0] d);
    longint v;
    v = {{30{d[33]}}, d};
`ifdef FIR_RX_ROUND_EN
    v = v + (64'sd1 <<< (SHIFT - 1));
`endif
    v = v >>> SHIFT;
    if (v > 32767)  return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [33:0] d, input bit keep);
    s_tvalid = 1'b1;
    s_tdata  = d;
    if (keep) exp_q.push_back(model(d));
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    m_tready = 1'b1;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || m_tvalid); i++) tick();
    check("drain_done", 34'(exp_q.size() == 0 && !m_tvalid), 34'd1);
    check("drain_level", 34'(level), 34'd0);
    m_tready = 1'b0;
  endtask

  // scoreboard: compare every output transfer against the expected queue
  always @(negedge aclk) begin
    if (!areset && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL pop_unexpected: got 0x%0h expected no output", m_tdata);
      end else begin
        check("pop_data", 34'(m_tdata), 34'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [33:0] r;

    vecs[0] = '{34'h0_0000_8000, 16'h0001};
    vecs[1] = '{34'h1_0000_0000, 16'h7fff};
    vecs[2] = '{34'h3_0000_0000, 16'h8000};
`ifdef FIR_RX_ROUND_EN
    vecs[3] = '{34'h0_0000_4000, 16'h0001};
    vecs[4] = '{34'h3_ffff_ffff, 16'h0000};
`else
    vecs[3] = '{34'h0_0000_4000, 16'h0000};
    vecs[4] = '{34'h3_ffff_ffff, 16'hffff};
`endif
    vecs[5] = '{34'h0_3fff_8000, 16'h7fff};
    vecs[6] = '{34'h0_4000_0000, 16'h7fff};
    vecs[7] = '{34'h3_c000_0000, 16'h8000};
    vecs[8] = '{34'h3_bfff_8000, 16'h8000};
    vecs[9] = '{34'h0_0012_8000, 16'h0025};

    // reset
    areset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0; clr_ovf = 1'b0;
    repeat (3) tick();
    check("rst_tvalid", 34'(m_tvalid), 34'd0);
    check("rst_tdata", 34'(m_tdata), 34'd0);
    check("rst_level", 34'(level), 34'd0);
    check("rst_ovf", 34'(ovf), 34'd0);
    check("rst_drop_cnt", 34'(drop_cnt), 34'd0);
    areset = 1'b0;
    tick();

    // single sample: latency of two cycles, level 0 -> 1 -> 0
    send(34'h0_0000_8000, 1'b1);
    check("lat_n1_tvalid", 34'(m_tvalid), 34'd0);
    check("lat_n1_level", 34'(level), 34'd0);
    tick();
    check("lat_n2_tvalid", 34'(m_tvalid), 34'd1);
    check("lat_n2_tdata", 34'(m_tdata), 34'h1);
    check("lat_n2_level", 34'(level), 34'd1);
    tick();
    check("hold_tdata", 34'(m_tdata), 34'h1);
    m_tready = 1'b1;
    tick();
    check("lat_pop_level", 34'(level), 34'd0);
    m_tready = 1'b0;

    // vector table at full rate
    m_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = vecs[i].din;
      exp_q.push_back(vecs[i].dout);
      tick();
    end
    s_tvalid = 1'b0;
    drain();

    // random stream with random backpressure
    for (int i = 0; i < 150; i++) begin
      m_tready = 1'($urandom_range(0, 1));
      if (level < 5'(DEPTH - 3) && $urandom_range(0, 3) != 0) begin
        r = {2'($urandom_range(0, 3)), 32'($urandom())};
        if ($urandom_range(0, 1) == 1) r = {{3{r[30]}}, r[30:0]};
        send(r, 1'b1);
      end else begin
        tick();
      end
    end
    drain();

    // overflow: DEPTH+3 samples into a stalled FIFO
    for (int i = 0; i < DEPTH + 3; i++) send(34'(i + 1) << 15, i < DEPTH);
    tick();
    tick();
    check("ovf_level", 34'(level), 34'(DEPTH));
    check("ovf_flag", 34'(ovf), 34'd1);
    check("ovf_drop_cnt", 34'(drop_cnt), 34'd3);
    drain();
    check("ovf_sticky", 34'(ovf), 34'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("clr_ovf_flag", 34'(ovf), 34'd0);
    check("clr_drop_cnt", 34'(drop_cnt), 34'd0);

    // full FIFO with a push and a pop in the same cycle
    for (int i = 0; i < DEPTH; i++) send(34'(i + 40) << 15, 1'b1);
    tick();
    check("fp_fill_level", 34'(level), 34'(DEPTH));
    for (int i = 0; i < 20; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 34'(i + 100) << 15;
      exp_q.push_back(model(s_tdata));
      if (i >= 1) m_tready = 1'b1;
      tick();
      if (i >= 1) check("fp_level", 34'(level), 34'(DEPTH));
    end
    s_tvalid = 1'b0;
    check("fp_drop_cnt", 34'(drop_cnt), 34'd0);
    check("fp_ovf", 34'(ovf), 34'd0);
    drain();

    // clr_ovf coincident with a drop
    for (int i = 0; i < DEPTH; i++) send(34'(i + 200) << 15, 1'b1);
    send(34'h0_0100_0000, 1'b0);
    tick();
    check("co_first_drop", 34'(drop_cnt), 34'd1);
    s_tvalid = 1'b1;
    s_tdata  = 34'h0_0200_0000;
    tick();
    s_tvalid = 1'b0;
    clr_ovf  = 1'b1;
    tick();
    clr_ovf  = 1'b0;
    check("co_ovf", 34'(ovf), 34'd1);
    check("co_drop_cnt", 34'(drop_cnt), 34'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("co_clr_drop_cnt", 34'(drop_cnt), 34'd0);
    drain();

    // reset asserted mid-stream, with a sample presented during reset
    for (int i = 0; i < 5; i++) send(34'(i + 7) << 15, 1'b1);
    areset   = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 34'h0_0000_8000;
    tick();
    check("mid_rst_tvalid", 34'(m_tvalid), 34'd0);
    check("mid_rst_level", 34'(level), 34'd0);
    s_tvalid = 1'b0;
    areset   = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    check("post_rst_tvalid", 34'(m_tvalid), 34'd0);
    check("post_rst_level", 34'(level), 34'd0);
    send(34'h0_0001_0000, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
